// File: rtl/dcache_refill.sv
// Data-cache miss handler: stalls on a load miss, fetches the aligned doubleword
// over TileLink-UL A/D, fills the line, and signals a fault on error or timeout.
module dcache_refill #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_req,
    input  logic [63:0] addr,
    input  logic        hit,
    output logic        stall,
    output logic        fault,
    output logic        a_valid,
    input  logic        a_ready,
    output logic [2:0]  a_opcode,
    output logic [2:0]  a_size,
    output logic [7:0]  a_mask,
    output logic [63:0] a_address,
    input  logic        d_valid,
    output logic        d_ready,
    input  logic [2:0]  d_opcode,
    input  logic        d_denied,
    input  logic [63:0] d_data,
    output logic        update,
    output logic [2:0]  opcode,
    output logic [63:0] update_data
);

    localparam logic [2:0]  OP_GET   = 3'd4;
    localparam logic [2:0]  SIZE_8B  = 3'd3;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_FILL = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    state_t      state;
    logic [63:0] miss_addr;
    logic [63:0] fill_data;
    logic [2:0]  fill_op;
    logic        denied_q;
    logic [15:0] tmo_cnt;
    logic        unused_addr_lo;

    // Control state and captured miss/response data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            miss_addr <= 64'd0;
            fill_data <= 64'd0;
            fill_op   <= 3'd0;
            denied_q  <= 1'b0;
            tmo_cnt   <= 16'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (load_req && !hit) begin
                        miss_addr <= addr;
                        state     <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (a_ready) begin
                        tmo_cnt <= 16'd0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A response arriving on the last counted cycle still wins.
                    if (d_valid) begin
                        fill_data <= d_data;
                        denied_q  <= d_denied;
                        fill_op   <= d_denied ? 3'd0 : d_opcode;
                        state     <= S_FILL;
                    end else if (tmo_cnt == TMO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                S_FILL:  state <= denied_q ? S_ERR : S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode the state register; only the IDLE miss term of stall looks at inputs.
    assign stall       = (state == S_REQ) || (state == S_WAIT) || (state == S_FILL) ||
                         ((state == S_IDLE) && load_req && !hit);
    assign fault       = (state == S_ERR);
    assign a_valid     = (state == S_REQ);
    assign a_opcode    = OP_GET;
    assign a_size      = SIZE_8B;
    assign a_mask      = 8'hFF;
    assign a_address   = (state == S_REQ) ? {miss_addr[63:3], 3'b000} : 64'd0;
    assign d_ready     = (state == S_IDLE) || (state == S_WAIT);
    assign update      = (state == S_FILL);
    assign opcode      = (state == S_FILL) ? fill_op : 3'd0;
    assign update_data = (state == S_FILL) ? fill_data : 64'd0;

    // Byte offset within the doubleword never reaches the bus.
    assign unused_addr_lo = ^miss_addr[2:0];

endmodule

// File: doc/dcache_refill.md
# dcache_refill

Miss handler for the direct-mapped data cache. It watches load operations in the memory stage and, on a miss, stalls the pipeline. It then fetches the aligned 8-byte doubleword over a TileLink-UL A/D channel pair and drives the cache's `update`/`opcode`/`update_data` port to fill the line. Bus errors and timeouts become a single-cycle `fault` pulse, and the line is left invalid.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in WAIT before the miss is abandoned; range 1..65535.
- `clk`  in  1  clock.
- `rst`  in  1  reset. One clock; reset is asynchronous and active-high.
- `load_req`  in  1  a load is presented to the cache this cycle.
- `addr`  in  64  load address; the pipeline holds it stable while `stall`=1.
- `hit`  in  1  cache hit for `addr` (combinational from cache).
- `stall`  out  1  freeze the memory stage.
- `fault`  out  1  one-cycle pulse: the load failed (denied or timeout).
- `a_valid`  out  1  TL-A request valid.
- `a_ready`  in  1  TL-A accepted.
- `a_opcode`  out  3  always Get (3'd4).
- `a_size`  out  3  always 3 (8 bytes).
- `a_mask`  out  8  always 8'hFF.
- `a_address`  out  64  `{miss_addr[63:3], 3'b000}`.
- `d_valid`  in  1  TL-D response valid.
- `d_ready`  out  1  TL-D accept.
- `d_opcode`  in  3  response opcode; AccessAckData = 3'd1.
- `d_denied`  in  1  response carries an error.
- `d_data`  in  64  response data.
- `update`  out  1  cache write strobe.
- `opcode`  out  3  to the cache. AccessAckData fills the line; any other value invalidates it.
- `update_data`  out  64  fill data.

## Operation
- Registered state: `state`, `miss_addr[63:0]`, `fill_data[63:0]`, `fill_op[2:0]`, `denied_q`, `tmo_cnt[15:0]`.
- FSM states and transitions:
  - IDLE:
    - if `load_req & ~hit`: latch `miss_addr`<=`addr`, go to REQ.
    - `d_ready`=1 in IDLE; any stray/late D beats are accepted and discarded.
  - REQ:
    - `a_valid`=1, held with constant fields until `a_ready`.
    - on `a_valid & a_ready`: clear `tmo_cnt`, go to WAIT.
  - WAIT:
    - `d_ready`=1.
    - on `d_valid`: latch `fill_data`<=`d_data`, latch `denied_q`<=`d_denied`, go to FILL.
    - latched `fill_op` = `d_denied ? 3'd0 : d_opcode`.
    - otherwise increment `tmo_cnt`; when it reaches `TIMEOUT-1` with no `d_valid`, go to ERR.
  - FILL:
    - `update`=1, `opcode`=`fill_op`, `update_data`=`fill_data`.
    - next state: ERR if `denied_q`, else IDLE.
  - ERR:
    - `fault`=1 for exactly one cycle, then IDLE.
    - No cache update on the timeout path.
- `stall` = (state ∈ {REQ, WAIT, FILL}) | (state==IDLE & `load_req` & ~`hit`).
  - `stall` is 0 in ERR, so the pipeline can take the exception.
  - The pipeline must drop `load_req` in the cycle `fault`=1.
- Outputs when not asserted:
  - `update_data`/`opcode` are 0 outside FILL.
  - `a_address` is 0 outside REQ.
- `hit` is ignored outside IDLE.
- Only one miss is outstanding; there are no request IDs.

## Timing
- Reset (async):
  - state=IDLE, all registers 0.
  - Outputs: `stall`=0, `fault`=0, `a_valid`=0, `update`=0, `d_ready`=1, `a_address`=0, `update_data`=0, `opcode`=0.
  - Reset mid-miss drops `a_valid` immediately; a later D beat is drained in IDLE.
- Miss with `a_ready`=1 and D returning k cycles after A acceptance (k≥1):
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, a_valid.
  - cycle 1+k: d_valid seen.
  - cycle 2+k: FILL, update.
  - cycle 3+k: IDLE; the cache now hits and stall=0.
- `a_ready` low holds REQ indefinitely; the timeout counts only in WAIT.
- A `d_valid` in the same cycle the counter reaches `TIMEOUT-1`: the response wins, go to FILL.
- A hit costs 0 cycles: stall=0 and no bus activity.

## Test plan
- Hit: `load_req`=1, `hit`=1 → stall=0, `a_valid` never asserted, `update` never asserted.
- Miss at addr 0x8000_1234, `a_ready`=1, AccessAckData with 0xDEAD_BEEF_0123_4567 after 3 cycles:
  - a_address=0x8000_1230, a_opcode=4, a_size=3, a_mask=FF.
  - `update`=1 with opcode=1 and that data exactly at cycle 5.
  - stall=1 for cycles 0..5.
- `a_ready` held low 10 cycles → a_valid and a_address stable for all 10 cycles, single handshake.
- Denied response (d_opcode=1, d_denied=1) → FILL with opcode=0, then `fault`=1 for one cycle with stall=0, then IDLE.
- No D response, TIMEOUT=8 → ERR after 8 WAIT cycles, fault pulse, no update. A late D beat in IDLE is accepted (d_ready=1) with no update.
- `rst` asserted during WAIT → a_valid/stall/update go 0 asynchronously, then the next miss proceeds normally.
